// File: rtl/lp805x_sync_pkg.sv
// Shared constants for the lp805x CDC sync FIFO and its write-side producer.
package lp805x_sync_pkg;

  localparam int SYNC_DATA_WIDTH = 40;
  localparam int BYTE_W          = 8;

  // Bit offset of byte lane `lane` within a packed word.
  function automatic int unsigned lane_bits(input int unsigned lane);
    return lane * BYTE_W;
  endfunction

endpackage

// File: rtl/lp805x_syncw_tx.sv
// Write-side producer for the lp805x sync FIFO: packs bytes little-endian into
// words, with one holding register feeding the wput/wrdy handshake.
module lp805x_syncw_tx
  import lp805x_sync_pkg::*;
#(
  parameter int DATA_WIDTH = SYNC_DATA_WIDTH,
  parameter int CNT_W      = 8
) (
  input  logic                  wclk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  wput,
  input  logic                  wrdy,
  output logic                  busy,
  output logic [CNT_W-1:0]      words_sent
);

  localparam int BYTES = DATA_WIDTH / BYTE_W;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [DATA_WIDTH-1:0] asm_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [DATA_WIDTH-1:0] asm_new;
  logic [DATA_WIDTH-1:0] lane_data;
  logic [CW-1:0]         cnt_q;
  logic                  full_q;
  logic                  hold_v_q;
  logic                  acc_b;
  logic                  acc_w;
  logic                  hold_free;
  logic                  complete;
  logic                  load_hold;

  assign in_rdy    = ~full_q;
  assign acc_b     = in_valid & ~full_q;
  assign acc_w     = hold_v_q & wrdy;
  assign hold_free = ~hold_v_q | acc_w;
  assign complete  = acc_b & ((cnt_q == CW'(BYTES - 1)) | in_last);

  // Lanes above cnt are still zero in asm, so OR-ing the new lane is enough;
  // this is also what zero-fills an early-closed word.
  assign lane_data = DATA_WIDTH'(in_data) << lane_bits(32'(cnt_q));
  assign asm_new   = asm_q | lane_data;

  // A pending full asm has priority; no byte can arrive while it waits.
  assign load_hold = hold_free & (full_q | complete);

  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      asm_q      <= '0;
      hold_q     <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      hold_v_q   <= 1'b0;
      words_sent <= '0;
    end else if (clr) begin
      asm_q      <= '0;
      hold_q     <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      hold_v_q   <= 1'b0;
      words_sent <= '0;
    end else begin
      if (acc_w) begin
        hold_v_q   <= 1'b0;
        words_sent <= words_sent + CNT_W'(1);
      end
      // A refill on the accepting edge overrides the clear above: no bubble.
      if (load_hold) begin
        hold_q   <= full_q ? asm_q : asm_new;
        hold_v_q <= 1'b1;
        asm_q    <= '0;
        cnt_q    <= '0;
        full_q   <= 1'b0;
      end else if (acc_b) begin
        asm_q <= asm_new;
        if (complete) begin
          full_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign wput     = hold_v_q;
  assign data_out = hold_q;
  assign busy     = (cnt_q != '0) | full_q | hold_v_q;

endmodule

// File: tb/tb_lp805x_syncw_tx.sv
// Bench for lp805x_syncw_tx: directed vector table, reset/corner sequences,
// randomized traffic against a word-queue model, and a 2-entry FIFO loopback.
module tb_lp805x_syncw_tx;
  import lp805x_sync_pkg::*;

  localparam int DW    = 40;
  localparam int BYTES = DW / 8;

  logic          wclk = 1'b0;
  logic          rclk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_rdy;
  logic [DW-1:0] data_out;
  logic          wput;
  logic          wrdy = 1'b0;
  logic          busy;
  logic [7:0]    words_sent;

  lp805x_syncw_tx #(.DATA_WIDTH(DW), .CNT_W(8)) dut (
    .wclk(wclk), .rst(rst), .clr(clr), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_rdy(in_rdy), .data_out(data_out), .wput(wput),
    .wrdy(wrdy), .busy(busy), .words_sent(words_sent)
  );

  always #5 wclk = ~wclk;
  always begin
    #18 rclk = 1'b1;
    #19 rclk = 1'b0;
  end

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference model: completed words waiting for the FIFO (hold + full asm),
  // bytes of the word being assembled, last accepted word, accept count.
  logic [DW-1:0] m_q[$];
  logic [7:0]    m_part[$];
  logic [DW-1:0] m_last;
  logic [7:0]    m_ws;

  task automatic model_reset();
    m_q.delete();
    m_part.delete();
    m_last = '0;
    m_ws   = '0;
  endtask

  task automatic check_model(string tag);
    logic [DW-1:0] exp_data;
    exp_data = (m_q.size() > 0) ? m_q[0] : m_last;
    check({tag, ".wput"},   64'(wput),       64'(m_q.size() > 0));
    check({tag, ".data"},   64'(data_out),   64'(exp_data));
    check({tag, ".in_rdy"}, 64'(in_rdy),     64'(m_q.size() < 2));
    check({tag, ".busy"},   64'(busy),       64'((m_part.size() != 0) || (m_q.size() != 0)));
    check({tag, ".ws"},     64'(words_sent), 64'(m_ws));
  endtask

  // One wclk edge: predict from pre-edge inputs, then compare #1 after the edge.
  task automatic tick(string tag);
    bit            aw;
    bit            ab;
    logic [DW-1:0] w;
    aw = (m_q.size() > 0) && (wrdy === 1'b1);
    ab = (in_valid === 1'b1) && (m_q.size() < 2);
    @(posedge wclk);
    if (clr) begin
      model_reset();
    end else begin
      if (aw) begin
        m_last = m_q.pop_front();
        m_ws   = m_ws + 8'd1;
      end
      if (ab) begin
        m_part.push_back(in_data);
        if ((m_part.size() == BYTES) || in_last) begin
          w = '0;
          foreach (m_part[k]) w[8*k +: 8] = m_part[k];
          m_q.push_back(w);
          m_part.delete();
        end
      end
    end
    #1;
    check_model(tag);
  endtask

  typedef struct {
    logic          v;
    logic [7:0]    d;
    logic          l;
    logic          w;
    logic          c;
    logic          e_wput;
    logic [DW-1:0] e_data;
    logic          e_rdy;
    logic          e_busy;
    logic [7:0]    e_ws;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic v, input logic [7:0] d, input logic l, input logic w,
                     input logic c, input logic e_wput, input logic [DW-1:0] e_data,
                     input logic e_rdy, input logic e_busy, input logic [7:0] e_ws);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.w = w; r.c = c;
    r.e_wput = e_wput; r.e_data = e_data; r.e_rdy = e_rdy; r.e_busy = e_busy; r.e_ws = e_ws;
    vq.push_back(r);
  endtask

  function automatic logic [DW-1:0] exp_word(int i);
    logic [DW-1:0] w;
    for (int j = 0; j < BYTES; j++) w[8*j +: 8] = 8'(BYTES * i + j);
    return w;
  endfunction

  logic [DW-1:0] fifo_q[$];
  logic          lb_en = 1'b0;
  int            rx_n = 0;
  logic [DW-1:0] rd_word;

  // Read side of the 2-entry FIFO: always gets when data is present.
  initial begin
    forever begin
      @(posedge rclk);
      if (lb_en && (fifo_q.size() > 0)) begin
        rd_word = fifo_q.pop_front();
        check($sformatf("loop_word%0d", rx_n), 64'(rd_word), 64'(exp_word(rx_n)));
        rx_n++;
      end
    end
  end

  initial begin
    int            sent;
    int            bi;
    bit            aw_pre;
    bit            ab_pre;
    logic [DW-1:0] dat;

    model_reset();

    // Async reset
    #1 rst = 1'b1;
    repeat (2) @(posedge wclk);
    #1;
    check("rst.wput",   64'(wput),       64'(0));
    check("rst.data",   64'(data_out),   64'(0));
    check("rst.in_rdy", 64'(in_rdy),     64'(1));
    check("rst.busy",   64'(busy),       64'(0));
    check("rst.ws",     64'(words_sent), 64'(0));
    #2 rst = 1'b0;
    #1;

    // Reset pulse mid-word after 3 bytes; next 5 bytes form a fresh word
    wrdy = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'hE1 + 8'(i);
      tick("midrst_pre");
    end
    #2 rst = 1'b1;
    #1;
    check("midrst.wput",   64'(wput),       64'(0));
    check("midrst.in_rdy", 64'(in_rdy),     64'(1));
    check("midrst.busy",   64'(busy),       64'(0));
    check("midrst.ws",     64'(words_sent), 64'(0));
    model_reset();
    #1 rst = 1'b0;
    wrdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'h61 + 8'(i);
      tick("midrst_post");
    end
    check("midrst.word", 64'(data_out), 64'(40'h6564636261));
    check("midrst.wput1", 64'(wput), 64'(1));
    in_valid = 1'b0;
    clr = 1'b1;
    tick("clr0");
    clr = 1'b0;

    // Directed vectors: basic pack, early close, backpressure, accept+refill, clear
    add(1, 8'h11, 0, 1, 0, 0, 40'h0, 1, 1, 0);
    add(1, 8'h22, 0, 1, 0, 0, 40'h0, 1, 1, 0);
    add(1, 8'h33, 0, 1, 0, 0, 40'h0, 1, 1, 0);
    add(1, 8'h44, 0, 1, 0, 0, 40'h0, 1, 1, 0);
    add(1, 8'h55, 0, 1, 0, 1, 40'h5544332211, 1, 1, 0);
    add(0, 8'h00, 0, 1, 0, 0, 40'h5544332211, 1, 0, 1);
    add(1, 8'hAA, 0, 1, 0, 0, 40'h5544332211, 1, 1, 1);
    add(1, 8'hBB, 1, 1, 0, 1, 40'h000000BBAA, 1, 1, 1);
    add(0, 8'h00, 1, 1, 0, 0, 40'h000000BBAA, 1, 0, 2);
    for (int i = 1; i <= 4; i++) add(1, 8'(i), 0, 0, 0, 0, 40'h000000BBAA, 1, 1, 2);
    add(1, 8'h05, 0, 0, 0, 1, 40'h0504030201, 1, 1, 2);
    for (int i = 6; i <= 9; i++) add(1, 8'(i), 0, 0, 0, 1, 40'h0504030201, 1, 1, 2);
    add(1, 8'h0A, 0, 0, 0, 1, 40'h0504030201, 0, 1, 2);
    add(1, 8'h0B, 0, 1, 0, 1, 40'h0A09080706, 1, 1, 3);
    add(0, 8'h00, 0, 0, 0, 1, 40'h0A09080706, 1, 1, 3);
    for (int i = 1; i <= 4; i++) add(1, 8'(16 * i), 0, 0, 0, 1, 40'h0A09080706, 1, 1, 3);
    add(1, 8'h50, 0, 1, 0, 1, 40'h5040302010, 1, 1, 4);
    add(0, 8'h00, 0, 1, 0, 0, 40'h5040302010, 1, 0, 5);
    add(0, 8'h00, 0, 1, 0, 0, 40'h5040302010, 1, 0, 5);
    add(1, 8'h77, 0, 0, 0, 0, 40'h5040302010, 1, 1, 5);
    add(1, 8'h88, 0, 1, 1, 0, 40'h0, 1, 0, 0);

    foreach (vq[i]) begin
      in_valid = vq[i].v;
      in_data  = vq[i].d;
      in_last  = vq[i].l;
      wrdy     = vq[i].w;
      clr      = vq[i].c;
      tick($sformatf("vec%0d.model", i));
      check($sformatf("vec%0d.wput", i),   64'(wput),       64'(vq[i].e_wput));
      check($sformatf("vec%0d.data", i),   64'(data_out),   64'(vq[i].e_data));
      check($sformatf("vec%0d.in_rdy", i), 64'(in_rdy),     64'(vq[i].e_rdy));
      check($sformatf("vec%0d.busy", i),   64'(busy),       64'(vq[i].e_busy));
      check($sformatf("vec%0d.ws", i),     64'(words_sent), 64'(vq[i].e_ws));
    end
    clr = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 99) < 70);
      in_data  = 8'($urandom);
      in_last  = ($urandom_range(0, 99) < 15);
      wrdy     = 1'($urandom_range(0, 1));
      clr      = ($urandom_range(0, 199) == 0);
      tick("rand");
    end

    // FIFO loopback: 256 words through a 2-entry FIFO read on rclk
    in_valid = 1'b0;
    in_last  = 1'b0;
    wrdy     = 1'b0;
    clr      = 1'b1;
    tick("lb_clr");
    clr   = 1'b0;
    lb_en = 1'b1;
    sent  = 0;
    bi    = 0;
    for (int cyc = 0; (cyc < 6000) && (sent < 256); cyc++) begin
      in_valid = (bi < 256 * BYTES);
      in_data  = 8'(bi);
      wrdy     = (fifo_q.size() < 2);
      aw_pre   = wput && wrdy;
      ab_pre   = in_valid && in_rdy;
      dat      = data_out;
      tick("loop");
      if (aw_pre) begin
        fifo_q.push_back(dat);
        sent++;
      end
      if (ab_pre) bi++;
    end
    in_valid = 1'b0;
    wrdy     = 1'b0;
    check("loop_sent", 64'(sent), 64'(256));
    for (int cyc = 0; (cyc < 200) && (fifo_q.size() > 0); cyc++) tick("drain");
    repeat (10) @(posedge wclk);
    #1;
    check("loop_rx_count", 64'(rx_n), 64'(256));
    check("loop_ws_wrap",  64'(words_sent), 64'(0));
    check("loop_busy",     64'(busy), 64'(0));
    lb_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
